// File: rtl/ioctl_rom_router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rom_router_pkg
// Description : Shared types and constants for the ioctl ROM router: the FIFO
//               item carrying one downloaded byte, the router FSM states and
//               the SDRAM byte-strobe encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package rom_router_pkg;

    localparam int IOCTL_AW = 25;
    localparam int IOCTL_DW = 8;

    // One downloaded byte together with its byte address
    typedef struct packed {
        logic [IOCTL_AW-1:0] addr;
        logic [IOCTL_DW-1:0] data;
    } fifo_item_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } state_e;

    // SDRAM byte strobes, {hi,lo}
    localparam logic [1:0] DS_LO = 2'b01;
    localparam logic [1:0] DS_HI = 2'b10;
    localparam logic [1:0] DS_W  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/ioctl_rom_router_fifo.sv
`default_nettype none
// ============================================================================
// Module      : router_fifo
// Description : Small synchronous FIFO of downloaded bytes. The head is
//               presented combinationally; a push into a full FIFO is
//               accepted only when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module router_fifo
    import rom_router_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic       pop_i,
    input  fifo_item_t wdata_i,
    output fifo_item_t rdata_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = FIFO_DEPTH[PTR_W:0];

    fifo_item_t       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    // Storage array: written on an accepted push, no reset needed
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap freely
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ioctl_rom_router.sv
`default_nettype none
// ============================================================================
// Module      : ioctl_rom_router
// Description : Routes the data_io byte stream to NUM_PORTS SDRAM toggle
//               request write ports, each with its own byte-address window
//               and word base. Bytes are buffered in a FIFO, optionally
//               packed into 16-bit words, and rom_loaded is raised when the
//               download ends.
// Revision    : 1.0 - initial release
// ============================================================================
module ioctl_rom_router
    import rom_router_pkg::*;
#(
    parameter int                          NUM_PORTS   = 2,
    parameter int                          SD_AW       = 23,
    parameter int                          FIFO_DEPTH  = 4,
    parameter int                          PACK        = 1,
    parameter logic [NUM_PORTS*25-1:0]     PORT_LO     = {NUM_PORTS{25'h0}},
    parameter logic [NUM_PORTS*25-1:0]     PORT_HI     = {NUM_PORTS{25'h1FFFFFF}},
    parameter logic [NUM_PORTS*SD_AW-1:0]  PORT_BASE   = {(NUM_PORTS*SD_AW){1'b0}},
    parameter logic [7:0]                  INDEX_MATCH = 8'h00
) (
    input  logic                         clk_sys,
    input  logic                         reset_n,
    input  logic                         ioctl_download,
    input  logic [7:0]                   ioctl_index,
    input  logic                         ioctl_wr,
    input  logic [24:0]                  ioctl_addr,
    input  logic [7:0]                   ioctl_dout,
    output logic [NUM_PORTS-1:0]         port_req,
    input  logic [NUM_PORTS-1:0]         port_ack,
    output logic [NUM_PORTS*SD_AW-1:0]   port_a,
    output logic [NUM_PORTS*2-1:0]       port_ds,
    output logic [NUM_PORTS*16-1:0]      port_d,
    output logic [NUM_PORTS-1:0]         port_we,
    output logic                         rom_loaded,
    output logic                         busy,
    output logic                         overflow
);

    // ------------------------------------------------------------------
    // Capture and FIFO
    // ------------------------------------------------------------------
    logic       wr_q;
    logic       dl_q;
    logic       overflow_q;
    logic       rom_loaded_q;
    logic       capture;
    logic       dl_fall;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    fifo_item_t fifo_in;
    fifo_item_t fifo_head;

    assign capture = ioctl_wr && !wr_q && ioctl_download && (ioctl_index == INDEX_MATCH);
    assign dl_fall = dl_q && !ioctl_download;
    assign fifo_in = '{addr: ioctl_addr, data: ioctl_dout};

    router_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_sys),
        .rst_ni  (reset_n),
        .push_i  (capture),
        .pop_i   (fifo_pop),
        .wdata_i (fifo_in),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Edge detectors and the two sticky status flags
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_q         <= 1'b0;
            dl_q         <= 1'b0;
            overflow_q   <= 1'b0;
            rom_loaded_q <= 1'b0;
        end else begin
            wr_q <= ioctl_wr;
            dl_q <= ioctl_download;
            // A pop in the same cycle frees a slot, so that case is not a drop
            if (capture && fifo_full && !fifo_pop) begin
                overflow_q <= 1'b1;
            end
            if (dl_fall) begin
                rom_loaded_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Router FSM and datapath state
    // ------------------------------------------------------------------
    state_e                       state_q,     state_d;
    logic                         hold_v_q,    hold_v_d;
    logic [24:0]                  hold_addr_q, hold_addr_d;
    logic [7:0]                   hold_data_q, hold_data_d;
    logic                         flush_q,     flush_d;
    logic [24:0]                  word_addr_q, word_addr_d;
    logic [1:0]                   word_ds_q,   word_ds_d;
    logic [15:0]                  word_d_q,    word_d_d;
    logic [NUM_PORTS-1:0]         tgt_q,       tgt_d;
    logic [NUM_PORTS-1:0]         req_q,       req_d;
    logic [NUM_PORTS*SD_AW-1:0]   a_q,         a_d;
    logic [NUM_PORTS*2-1:0]       ds_q,        ds_d;
    logic [NUM_PORTS*16-1:0]      d_q,         d_d;

    // Window decode and SDRAM word address for the pending word, per port
    logic [NUM_PORTS-1:0]         hit;
    logic [NUM_PORTS*SD_AW-1:0]   calc_a;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        localparam logic [24:0]      LO   = PORT_LO[gi*25 +: 25];
        localparam logic [24:0]      HI   = PORT_HI[gi*25 +: 25];
        localparam logic [SD_AW-1:0] BASE = PORT_BASE[gi*SD_AW +: SD_AW];

        assign hit[gi] = (word_addr_q >= LO) && (word_addr_q <= HI);
        // Wraps at SD_AW bits by design
        assign calc_a[gi*SD_AW +: SD_AW] = BASE + SD_AW'((word_addr_q - LO) >> 1);
    end

    // State and datapath registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            hold_v_q    <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            flush_q     <= 1'b0;
            word_addr_q <= '0;
            word_ds_q   <= '0;
            word_d_q    <= '0;
            tgt_q       <= '0;
            req_q       <= '0;
            a_q         <= '0;
            ds_q        <= '0;
            d_q         <= '0;
        end else begin
            state_q     <= state_d;
            hold_v_q    <= hold_v_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            flush_q     <= flush_d;
            word_addr_q <= word_addr_d;
            word_ds_q   <= word_ds_d;
            word_d_q    <= word_d_d;
            tgt_q       <= tgt_d;
            req_q       <= req_d;
            a_q         <= a_d;
            ds_q        <= ds_d;
            d_q         <= d_d;
        end
    end

    // Next state: pop/pack the FIFO head, issue to targeted ports, await acks
    always_comb begin
        state_d     = state_q;
        hold_v_d    = hold_v_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        flush_d     = flush_q || dl_fall;
        word_addr_d = word_addr_q;
        word_ds_d   = word_ds_q;
        word_d_d    = word_d_q;
        tgt_d       = tgt_q;
        req_d       = req_q;
        a_d         = a_q;
        ds_d        = ds_q;
        d_d         = d_q;
        fifo_pop    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = POP;
                end else if (flush_q) begin
                    if (hold_v_q) begin
                        state_d = POP;
                    end else begin
                        flush_d = dl_fall;
                    end
                end
            end

            POP: begin
                if (!fifo_empty) begin
                    if (PACK != 0) begin
                        if (hold_v_q) begin
                            hold_v_d    = 1'b0;
                            word_addr_d = hold_addr_q;
                            state_d     = ISSUE;
                            if (fifo_head.addr == hold_addr_q + 25'd1) begin
                                fifo_pop  = 1'b1;
                                word_ds_d = DS_W;
                                word_d_d  = {fifo_head.data, hold_data_q};
                            end else begin
                                // Head stays in the FIFO and is handled on the next pass
                                word_ds_d = DS_LO;
                                word_d_d  = {hold_data_q, hold_data_q};
                            end
                        end else if (!fifo_head.addr[0]) begin
                            fifo_pop    = 1'b1;
                            hold_v_d    = 1'b1;
                            hold_addr_d = fifo_head.addr;
                            hold_data_d = fifo_head.data;
                            state_d     = IDLE;
                        end else begin
                            fifo_pop    = 1'b1;
                            word_addr_d = fifo_head.addr;
                            word_ds_d   = DS_HI;
                            word_d_d    = {fifo_head.data, fifo_head.data};
                            state_d     = ISSUE;
                        end
                    end else begin
                        fifo_pop    = 1'b1;
                        word_addr_d = fifo_head.addr;
                        word_ds_d   = fifo_head.addr[0] ? DS_HI : DS_LO;
                        word_d_d    = {fifo_head.data, fifo_head.data};
                        state_d     = ISSUE;
                    end
                end else if (hold_v_q && flush_q) begin
                    // Download over and FIFO drained: flush the lone even byte
                    hold_v_d    = 1'b0;
                    flush_d     = dl_fall;
                    word_addr_d = hold_addr_q;
                    word_ds_d   = DS_LO;
                    word_d_d    = {hold_data_q, hold_data_q};
                    state_d     = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end

            ISSUE: begin
                tgt_d = hit;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (hit[i]) begin
                        req_d[i]              = ~req_q[i];
                        a_d[i*SD_AW +: SD_AW] = calc_a[i*SD_AW +: SD_AW];
                        ds_d[i*2 +: 2]        = word_ds_q;
                        d_d[i*16 +: 16]       = word_d_q;
                    end
                end
                // An address outside every window is simply dropped
                state_d = (|hit) ? WAIT : IDLE;
            end

            WAIT: begin
                if (((port_ack ^ req_q) & tgt_q) == '0) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign port_req   = req_q;
    assign port_a     = a_q;
    assign port_ds    = ds_q;
    assign port_d     = d_q;
    assign port_we    = {NUM_PORTS{ioctl_download}};
    assign rom_loaded = rom_loaded_q;
    assign overflow   = overflow_q;
    assign busy       = !fifo_empty || hold_v_q || (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ioctl_rom_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_ioctl_rom_router
// Description : Self-checking bench for ioctl_rom_router with two ports,
//               byte packing and a 4-entry FIFO. A byte-level reference
//               model predicts the SDRAM writes; a monitor records every
//               req toggle and an sdram-side responder acknowledges them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ioctl_rom_router;

    localparam logic [24:0] LO0   = 25'h0000000;
    localparam logic [24:0] HI0   = 25'h0007FFF;
    localparam logic [24:0] LO1   = 25'h0008000;
    localparam logic [24:0] HI1   = 25'h000FFFF;
    localparam logic [22:0] BASE0 = 23'h000000;
    localparam logic [22:0] BASE1 = 23'h004000;

    typedef struct packed {
        logic [7:0]  port;
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
    } wr_t;

    logic        clk_sys        = 1'b0;
    logic        reset_n        = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index    = 8'h00;
    logic        ioctl_wr       = 1'b0;
    logic [24:0] ioctl_addr     = '0;
    logic [7:0]  ioctl_dout     = '0;
    logic [1:0]  port_req;
    logic [1:0]  port_ack       = '0;
    logic [45:0] port_a;
    logic [3:0]  port_ds;
    logic [31:0] port_d;
    logic [1:0]  port_we;
    logic        rom_loaded;
    logic        busy;
    logic        overflow;

    int   checks  = 0;
    int   errors  = 0;
    logic ack_en  = 1'b1;
    int   ack_max = 0;
    int   ack_dly [2] = '{0, 0};

    wr_t  obs_q[$];
    wr_t  exp_q[$];
    wr_t  last_rec [2];
    logic [1:0] last_req = '0;

    logic        m_hold  = 1'b0;
    logic [24:0] m_haddr = '0;
    logic [7:0]  m_hdata = '0;

    ioctl_rom_router #(
        .NUM_PORTS   (2),
        .SD_AW       (23),
        .FIFO_DEPTH  (4),
        .PACK        (1),
        .PORT_LO     ({LO1, LO0}),
        .PORT_HI     ({HI1, HI0}),
        .PORT_BASE   ({BASE1, BASE0}),
        .INDEX_MATCH (8'h00)
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .port_req       (port_req),
        .port_ack       (port_ack),
        .port_a         (port_a),
        .port_ds        (port_ds),
        .port_d         (port_d),
        .port_we        (port_we),
        .rom_loaded     (rom_loaded),
        .busy           (busy),
        .overflow       (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: one write per targeted port for a finished word
    task automatic emit(input logic [24:0] a, input logic [1:0] ds, input logic [15:0] d);
        logic [24:0] lo;
        logic [24:0] hi;
        logic [22:0] base;
        for (int p = 0; p < 2; p++) begin
            lo   = (p == 0) ? LO0 : LO1;
            hi   = (p == 0) ? HI0 : HI1;
            base = (p == 0) ? BASE0 : BASE1;
            if (a >= lo && a <= hi) begin
                exp_q.push_back('{8'(p), 23'(base + ((a - lo) >> 1)), ds, d});
            end
        end
    endtask

    task automatic model_byte(input logic [24:0] a, input logic [7:0] d);
        if (m_hold) begin
            m_hold = 1'b0;
            if (a == m_haddr + 25'd1) begin
                emit(m_haddr, 2'b11, {d, m_hdata});
                return;
            end
            emit(m_haddr, 2'b01, {m_hdata, m_hdata});
        end
        if (a[0] == 1'b0) begin
            m_hold  = 1'b1;
            m_haddr = a;
            m_hdata = d;
        end else begin
            emit(a, 2'b10, {d, d});
        end
    endtask

    task automatic model_flush();
        if (m_hold) begin
            emit(m_haddr, 2'b01, {m_hdata, m_hdata});
            m_hold = 1'b0;
        end
    endtask

    task automatic send(input logic [24:0] a, input logic [7:0] d, input int gap);
        @(negedge clk_sys);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr   = 1'b0;
        repeat (gap) @(negedge clk_sys);
    endtask

    task automatic send_m(input logic [24:0] a, input logic [7:0] d, input int gap);
        send(a, d, gap);
        model_byte(a, d);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || port_req != port_ack) && n < 2000) begin
            @(negedge clk_sys);
            n++;
        end
        chk({tag, "_idle_timeout"}, 64'(n < 2000), 64'd1);
    endtask

    task automatic check_writes(input string tag);
        int n;
        chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_write"}, 64'(obs_q[i]), 64'(exp_q[i]));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    // Monitor: record every req toggle with the port values driven alongside it
    always @(posedge clk_sys) begin
        #1;
        if (!reset_n) begin
            last_req = '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (port_req[p] !== last_req[p]) begin
                    last_rec[p] = '{8'(p), port_a[p*23 +: 23], port_ds[p*2 +: 2], port_d[p*16 +: 16]};
                    obs_q.push_back(last_rec[p]);
                    last_req[p] = port_req[p];
                end
            end
        end
    end

    // SDRAM-side responder: ack after a random delay, values must hold until then
    always @(negedge clk_sys) begin
        if (!reset_n) begin
            port_ack = '0;
        end else if (ack_en) begin
            for (int p = 0; p < 2; p++) begin
                if (port_ack[p] !== port_req[p]) begin
                    if (ack_dly[p] == 0) begin
                        chk("hold_stable",
                            64'({port_a[p*23 +: 23], port_ds[p*2 +: 2], port_d[p*16 +: 16]}),
                            64'({last_rec[p].a, last_rec[p].ds, last_rec[p].d}));
                        port_ack[p] = port_req[p];
                        ack_dly[p]  = $urandom_range(0, ack_max);
                    end else begin
                        ack_dly[p]--;
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] ra;
        ra = '0;

        // Reset state
        repeat (3) @(negedge clk_sys);
        chk("rst_req",      64'(port_req),   64'd0);
        chk("rst_a",        64'(port_a),     64'd0);
        chk("rst_ds",       64'(port_ds),    64'd0);
        chk("rst_d",        64'(port_d),     64'd0);
        chk("rst_loaded",   64'(rom_loaded), 64'd0);
        chk("rst_overflow", 64'(overflow),   64'd0);
        chk("rst_busy",     64'(busy),       64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        ioctl_download = 1'b1;
        @(negedge clk_sys);
        chk("we_high", 64'(port_we), 64'd3);

        // Foreign index is ignored
        ioctl_index = 8'h01;
        send(25'h0, 8'h99, 3);
        chk("index_ignored", 64'(busy), 64'd0);
        ioctl_index = 8'h00;

        // Packed pair, with first-toggle latency
        send_m(25'h0, 8'h11, 4);
        @(negedge clk_sys);
        ioctl_addr = 25'h1;
        ioctl_dout = 8'h22;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr   = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        chk("latency_before", 64'(port_req[0]), 64'd0);
        @(negedge clk_sys);
        chk("latency_toggle", 64'(port_req[0]), 64'd1);
        model_byte(25'h1, 8'h22);
        wait_idle("pair");
        check_writes("pair");

        // Non-consecutive bytes
        send_m(25'h4, 8'hAA, 3);
        send_m(25'h9, 8'hBB, 3);
        wait_idle("noncons");
        check_writes("noncons");

        // Pair in the second window only
        send_m(25'h8002, 8'h33, 3);
        send_m(25'h8003, 8'h44, 3);
        wait_idle("port1");
        check_writes("port1");

        // Pair outside every window
        send_m(25'h10000, 8'h55, 3);
        send_m(25'h10001, 8'h66, 3);
        wait_idle("discard");
        check_writes("discard");

        // Held byte flushed at end of download
        send_m(25'h6, 8'h10, 4);
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        chk("loaded_before_fall", 64'(rom_loaded), 64'd0);
        @(negedge clk_sys);
        chk("loaded_after_fall", 64'(rom_loaded), 64'd1);
        chk("we_low", 64'(port_we), 64'd0);
        model_flush();
        wait_idle("flush");
        check_writes("flush");

        // Randomised stream across both windows and beyond
        ack_max = 2;
        ioctl_download = 1'b1;
        repeat (2) @(negedge clk_sys);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) != 0) ra = ra + 25'd1;
            else                            ra = 25'($urandom_range(0, 32'h17FFF));
            send_m(ra, 8'($urandom), $urandom_range(8, 10));
        end
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        model_flush();
        wait_idle("random");
        check_writes("random");
        chk("random_no_overflow", 64'(overflow), 64'd0);

        // Ack withheld while six bytes arrive: one in flight, four buffered, one dropped
        ack_max = 0;
        ack_en  = 1'b0;
        ioctl_download = 1'b1;
        repeat (2) @(negedge clk_sys);
        for (int i = 0; i < 6; i++) begin
            send(25'h201 + 25'(2 * i), 8'h60 + 8'(i), 0);
            if (i < 5) model_byte(25'h201 + 25'(2 * i), 8'h60 + 8'(i));
        end
        repeat (20) @(negedge clk_sys);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_busy", 64'(busy),     64'd1);
        ack_en = 1'b1;
        wait_idle("ovf");
        check_writes("ovf");
        chk("ovf_loaded_kept", 64'(rom_loaded), 64'd1);

        // Reset while a write is outstanding
        ack_en = 1'b0;
        send_m(25'h301, 8'h77, 0);
        begin
            int n = 0;
            while (port_req == port_ack && n < 50) begin
                @(negedge clk_sys);
                n++;
            end
            chk("midrst_reach_wait", 64'(n < 50), 64'd1);
        end
        check_writes("midrst_pre");
        @(negedge clk_sys);
        reset_n = 1'b0;
        #1;
        chk("midrst_req",      64'(port_req),   64'd0);
        chk("midrst_busy",     64'(busy),       64'd0);
        chk("midrst_overflow", 64'(overflow),   64'd0);
        chk("midrst_loaded",   64'(rom_loaded), 64'd0);
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        ack_en  = 1'b1;
        m_hold  = 1'b0;
        repeat (2) @(negedge clk_sys);
        send_m(25'h0, 8'h55, 3);
        send_m(25'h1, 8'h66, 3);
        wait_idle("postrst");
        check_writes("postrst");

        @(negedge clk_sys);
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        chk("final_loaded", 64'(rom_loaded), 64'd1);
        wait_idle("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
